// File: rtl/conv_mac_accumulator_pkg.sv
// Shared widths, types and the saturating accumulate helper for the convolution MAC.
package conv_mac_pkg;

    localparam int WALLACE_W    = 16;
    localparam int PROD_W       = 2 * WALLACE_W;
    localparam int ACC_W_DEF    = 40;
    localparam int MAX_TAPS_DEF = 256;

    typedef logic [PROD_W-1:0]    prod_t;
    typedef logic [ACC_W_DEF-1:0] acc_t;

    // Adds a product to a running sum that lives in the low `width` bits of acc.
    // Returns {ovf, sum}; on overflow the sum is clamped to all-ones at `width` bits.
    function automatic logic [ACC_W_DEF:0] sat_add(acc_t acc, prod_t prod, int unsigned width);
        logic [ACC_W_DEF:0] sum_v;
        logic [ACC_W_DEF:0] lim_v;
        logic [ACC_W_DEF:0] one_v;
        logic               ovf_v;
        one_v = {{ACC_W_DEF{1'b0}}, 1'b1};
        sum_v = {1'b0, acc} + {{(ACC_W_DEF + 1 - PROD_W){1'b0}}, prod};
        lim_v = (one_v << width) - one_v;
        ovf_v = |(sum_v >> width);
        if (ovf_v) begin
            return {1'b1, lim_v[ACC_W_DEF-1:0]};
        end else begin
            return {1'b0, sum_v[ACC_W_DEF-1:0]};
        end
    endfunction

endpackage

// File: rtl/conv_mac_accumulator_wallace.sv
// 16x16 unsigned partial-product multiplier feeding the MAC accumulate stage.
module wallace
    import conv_mac_pkg::*;
(
    input  logic [WALLACE_W-1:0] a,
    input  logic [WALLACE_W-1:0] b,
    output prod_t                sum
);

    // Sum of shifted partial products; the reduction tree shape is left to synthesis.
    always_comb begin
        sum = '0;
        for (int i = 0; i < WALLACE_W; i++) begin
            if (b[i]) begin
                sum = sum + (PROD_W'(a) << i);
            end else begin
                sum = sum;
            end
        end
    end

endmodule

// File: rtl/conv_mac_accumulator.sv
// Registers operand pairs, multiplies them and accumulates one saturated sum per convolution window.
module conv_mac_accumulator
    import conv_mac_pkg::*;
#(
    parameter int DATA_W   = WALLACE_W,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int MAX_TAPS = MAX_TAPS_DEF,
    parameter int CNT_W    = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_taps,
    output logic              out_ovf,
    output logic              out_trunc
);

    logic [DATA_W-1:0] p_a_q, p_a_d;
    logic [DATA_W-1:0] p_b_q, p_b_d;
    logic              p_last_q, p_last_d;
    logic              p_valid_q, p_valid_d;
    logic              rdy_q, rdy_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  out_acc_q, out_acc_d;
    logic [CNT_W-1:0]  out_taps_q, out_taps_d;
    logic              out_ovf_q, out_ovf_d;
    logic              out_trunc_q, out_trunc_d;

    prod_t              p_sum_s;
    acc_t               base_s;
    logic [ACC_W_DEF:0] sat_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               close_s;
    logic               stall_s;
    logic               fire_s;
    logic               accept_s;

    wallace u_wallace (
        .a   (p_a_q),
        .b   (p_b_q),
        .sum (p_sum_s)
    );

    // Only a closing tap can stall, and only when the previous result is still unread.
    always_comb begin
        base_s    = (cnt_q == '0) ? '0 : acc_t'(acc_q);
        sat_s     = sat_add(base_s, p_sum_s, ACC_W);
        cnt_inc_s = cnt_q + CNT_W'(1);
        close_s   = p_last_q || (cnt_inc_s == CNT_W'(MAX_TAPS));
        stall_s   = p_valid_q && close_s && out_valid_q && !out_ready;
        fire_s    = p_valid_q && !stall_s;
        in_ready  = rdy_q && !stall_s;
        accept_s  = in_valid && in_ready;
    end

    // Next-state for the product, accumulate and output registers.
    always_comb begin
        p_a_d       = p_a_q;
        p_b_d       = p_b_q;
        p_last_d    = p_last_q;
        p_valid_d   = p_valid_q;
        rdy_d       = 1'b1;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_taps_d  = out_taps_q;
        out_ovf_d   = out_ovf_q;
        out_trunc_d = out_trunc_q;

        if (accept_s) begin
            p_a_d     = in_a;
            p_b_d     = in_b;
            p_last_d  = in_last;
            p_valid_d = 1'b1;
        end else if (!stall_s) begin
            p_valid_d = 1'b0;
        end else begin
            p_valid_d = p_valid_q;
        end

        if (fire_s && close_s) begin
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_acc_d   = sat_s[ACC_W-1:0];
            out_taps_d  = cnt_inc_s;
            out_ovf_d   = ovf_q || sat_s[ACC_W_DEF];
            out_trunc_d = !p_last_q;
        end else if (fire_s) begin
            acc_d = sat_s[ACC_W-1:0];
            cnt_d = cnt_inc_s;
            ovf_d = ovf_q || sat_s[ACC_W_DEF];
        end else begin
            acc_d = acc_q;
        end

        // A close on the same edge as the consumer's accept reloads the result back-to-back.
        if (fire_s && close_s) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset discards any partial window and pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_a_q       <= '0;
            p_b_q       <= '0;
            p_last_q    <= 1'b0;
            p_valid_q   <= 1'b0;
            rdy_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_taps_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_trunc_q <= 1'b0;
        end else begin
            p_a_q       <= p_a_d;
            p_b_q       <= p_b_d;
            p_last_q    <= p_last_d;
            p_valid_q   <= p_valid_d;
            rdy_q       <= rdy_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_taps_q  <= out_taps_d;
            out_ovf_q   <= out_ovf_d;
            out_trunc_q <= out_trunc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_taps  = out_taps_q;
    assign out_ovf   = out_ovf_q;
    assign out_trunc = out_trunc_q;

endmodule
